// File: rtl/binary_to_display.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// binary_to_display
//
// Registered hexadecimal-to-seven-segment decoder for a single display digit.
// A 4-bit nibble (0x0-0xF) is decoded into the seven segment drives a-g and
// captured in one output register, so the display pins only ever change on
// a rising clock edge and never glitch.
//
// Parameters
//   ACTIVE_LOW     0: lit segment = 1 (common-cathode)
//                  1: every segment inverted (common-anode)
//
// Ports
//   clock          system clock, all state changes on its rising edge
//   reset          synchronous active-high reset, blanks the digit
//   binary_number  nibble to display, unsigned 0x0-0xF
//   segment_a      top segment
//   segment_b      upper-right segment
//   segment_c      lower-right segment
//   segment_d      bottom segment
//   segment_e      lower-left segment
//   segment_f      upper-left segment
//   segment_g      middle segment
// ---------------------------------------------------------------------------
module binary_to_display #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] binary_number,
  output logic       segment_a,
  output logic       segment_b,
  output logic       segment_c,
  output logic       segment_d,
  output logic       segment_e,
  output logic       segment_f,
  output logic       segment_g
);

  // XOR mask applied to the active-high pattern. With ACTIVE_LOW set it is
  // all ones, which also turns the all-off blank into 1111111.
  localparam logic [6:0] POLARITY_MASK = {7{ACTIVE_LOW}};
  localparam logic [6:0] BLANK         = 7'b000_0000 ^ POLARITY_MASK;

  // Segment order throughout is {a,b,c,d,e,f,g}, a in the MSB.
  logic [6:0] glyph;
  logic [6:0] segments_next;
  logic [6:0] segments_reg;

  // Active-high glyph table. 6 carries the top bar and 9 the bottom bar;
  // B and D are drawn lowercase so they cannot be mistaken for 8 and 0.
  // All 16 codes are listed, so the case is complete without a default.
  always_comb begin
    glyph = 7'b000_0000;
    unique case (binary_number)
      4'h0: glyph = 7'b111_1110;
      4'h1: glyph = 7'b011_0000;
      4'h2: glyph = 7'b110_1101;
      4'h3: glyph = 7'b111_1001;
      4'h4: glyph = 7'b011_0011;
      4'h5: glyph = 7'b101_1011;
      4'h6: glyph = 7'b101_1111;
      4'h7: glyph = 7'b111_0000;
      4'h8: glyph = 7'b111_1111;
      4'h9: glyph = 7'b111_1011;
      4'hA: glyph = 7'b111_0111;
      4'hB: glyph = 7'b001_1111;
      4'hC: glyph = 7'b100_1110;
      4'hD: glyph = 7'b011_1101;
      4'hE: glyph = 7'b100_1111;
      4'hF: glyph = 7'b100_0111;
    endcase
  end

  assign segments_next = glyph ^ POLARITY_MASK;

  // Reset wins over decode; the first edge after reset loads the glyph of
  // whatever nibble is present at that edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      segments_reg <= BLANK;
    end else begin
      segments_reg <= segments_next;
    end
  end

  assign segment_a = segments_reg[6];
  assign segment_b = segments_reg[5];
  assign segment_c = segments_reg[4];
  assign segment_d = segments_reg[3];
  assign segment_e = segments_reg[2];
  assign segment_f = segments_reg[1];
  assign segment_g = segments_reg[0];

endmodule

// File: tb/tb_binary_to_display.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// tb_binary_to_display
//
// Scoreboard bench for binary_to_display. Two instances (common-cathode and
// common-anode) share the same stimulus. The driver changes inputs on the
// falling edge and pushes the hand-written active-high expectation for the
// coming rising edge; the monitor pops one entry a quarter period after each
// rising edge and compares both instances, then re-checks just before the
// next rising edge that nothing moved in between.
// ---------------------------------------------------------------------------
module tb_binary_to_display;

  typedef struct {
    bit         chk;
    logic [6:0] exp;
    string      name;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] binary_number = 4'h8;

  logic seg0_a, seg0_b, seg0_c, seg0_d, seg0_e, seg0_f, seg0_g;
  logic seg1_a, seg1_b, seg1_c, seg1_d, seg1_e, seg1_f, seg1_g;
  logic [6:0] seg0;
  logic [6:0] seg1;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  binary_to_display #(.ACTIVE_LOW(1'b0)) dut_cc (
    .clock(clock), .reset(reset), .binary_number(binary_number),
    .segment_a(seg0_a), .segment_b(seg0_b), .segment_c(seg0_c),
    .segment_d(seg0_d), .segment_e(seg0_e), .segment_f(seg0_f),
    .segment_g(seg0_g)
  );

  binary_to_display #(.ACTIVE_LOW(1'b1)) dut_ca (
    .clock(clock), .reset(reset), .binary_number(binary_number),
    .segment_a(seg1_a), .segment_b(seg1_b), .segment_c(seg1_c),
    .segment_d(seg1_d), .segment_e(seg1_e), .segment_f(seg1_f),
    .segment_g(seg1_g)
  );

  assign seg0 = {seg0_a, seg0_b, seg0_c, seg0_d, seg0_e, seg0_f, seg0_g};
  assign seg1 = {seg1_a, seg1_b, seg1_c, seg1_d, seg1_e, seg1_f, seg1_g};

  // Hand-written active-high glyphs, indexed by nibble.
  logic [6:0] table_hi [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // One rising edge of stimulus: inputs set on the falling edge before it.
  task automatic step(input bit rst, input logic [3:0] nib, input logic [6:0] exp,
                      input string name);
    exp_t e;
    @(negedge clock);
    reset = rst;
    binary_number = nib;
    e.chk = 1'b1;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Same as step, but pulses a different nibble between the edges.
  task automatic step_glitch(input logic [3:0] nib, input logic [3:0] glitch,
                             input logic [6:0] exp, input string name);
    step(1'b0, nib, exp, name);
    #1 binary_number = glitch;
    #1 binary_number = nib;
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [6:0] hold0;
    logic [6:0] hold1;
    bit         hold_valid;
    string      hold_name;
    hold_valid = 1'b0;
    hold0 = '0;
    hold1 = '0;
    forever begin
      @(posedge clock);
      #2.5;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check({e.name, " cc"}, seg0, e.exp);
          check({e.name, " ca"}, seg1, ~e.exp);
          hold0 = e.exp;
          hold1 = ~e.exp;
          hold_name = e.name;
          hold_valid = 1'b1;
        end else begin
          hold_valid = 1'b0;
        end
      end else begin
        hold_valid = 1'b0;
      end
      @(negedge clock);
      #4;
      if (hold_valid) begin
        check({hold_name, " hold cc"}, seg0, hold0);
        check({hold_name, " hold ca"}, seg1, hold1);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    // Reset held two edges with 0x8 on the input, then released.
    step(1'b1, 4'h8, 7'b0000000, "reset1");
    step(1'b1, 4'h8, 7'b0000000, "reset2");
    step(1'b0, 4'h8, 7'b1111111, "release_8");

    // Directed sequence
    step(1'b0, 4'h0, 7'b1111110, "dir_0");
    step(1'b0, 4'h5, 7'b1011011, "dir_5");
    step(1'b0, 4'hC, 7'b1001110, "dir_C");
    step(1'b0, 4'hB, 7'b0011111, "dir_B");
    step(1'b0, 4'hF, 7'b1000111, "dir_F");

    // Exhaustive sweep on consecutive edges
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), table_hi[i], $sformatf("sweep_%h", i));
    end

    // 0x1 -> 0x7: input changes on the falling edge, output must hold 0110000
    // until the following rising edge (covered by the hold check).
    step(1'b0, 4'h1, 7'b0110000, "lat_1");
    step(1'b0, 4'h7, 7'b1110000, "lat_7");

    // Glitch between edges must not reach the outputs.
    step(1'b0, 4'h3, 7'b1111001, "pre_glitch_3");
    step_glitch(4'h3, 4'hA, 7'b1111001, "glitch_3");

    // Mid-stream reset while showing 0x9
    step(1'b0, 4'h9, 7'b1111011, "show_9");
    step(1'b1, 4'h9, 7'b0000000, "mid_reset");
    step(1'b0, 4'h9, 7'b1111011, "after_reset_9");

    // Values with explicit common-anode expectations (0000001, 0110000)
    step(1'b0, 4'h0, 7'b1111110, "pol_0");
    step(1'b0, 4'hE, 7'b1001111, "pol_E");
    step(1'b1, 4'hE, 7'b0000000, "pol_reset");

    repeat (3) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left in scoreboard, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_to_display.md
# binary_to_display

Registered hexadecimal-to-seven-segment decoder. Converts a 4-bit binary nibble (0x0–0xF) into the seven segment drive signals a–g of a single digit, for the board's seven-segment display. Sits between the sensor-value formatting logic and the display pins. The output is registered on the system clock so the pins are glitch-free.

## Interface
- ACTIVE_LOW, default 0: output polarity.
  - 0: segment lit = 1 (common-cathode).
  - 1: every segment output is inverted (common-anode).
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- binary_number  input  4  nibble to display, unsigned 0x0–0xF.
- segment_a  output  1  top segment.
- segment_b  output  1  upper-right segment.
- segment_c  output  1  lower-right segment.
- segment_d  output  1  bottom segment.
- segment_e  output  1  lower-left segment.
- segment_f  output  1  upper-left segment.
- segment_g  output  1  middle segment.

## Operation
- A single 7-bit output register {a,b,c,d,e,f,g} (a = MSB) drives the seven segment ports directly.
- Decode table, active-high, written as abcdefg:
  - 0: 1111110; 1: 0110000; 2: 1101101; 3: 1111001
  - 4: 0110011; 5: 1011011; 6: 1011111; 7: 1110000
  - 8: 1111111; 9: 1111011; A: 1110111; b: 0011111
  - C: 1001110; d: 0111101; E: 1001111; F: 1000111
- Glyph rules:
  - 6 includes the top segment (a).
  - 9 includes the bottom segment (d).
  - B and D display as lowercase "b" and "d" so they are distinct from 8 and 0.
- The decode is total. All 16 codes are defined, so no default or blank case is reachable from normal input. X/Z on the input is not specified.
- ACTIVE_LOW=1: the register holds the bitwise inverse of the table value, and the inverse of the reset value.
- The block has no internal state other than the output register.

## Timing
- Latency: 1 clock.
  - binary_number is sampled at rising edge N.
  - The segments reflect its decode from edge N until edge N+1.
- Input changes between edges have no effect until the next rising edge. The outputs never change except on a rising edge.
- Reset:
  - reset=1 at a rising edge loads the blank pattern: all segments off, i.e. 0000000 for ACTIVE_LOW=0, 1111111 for ACTIVE_LOW=1.
  - Reset has priority over decode.
- The first edge with reset=0 loads the decode of the binary_number present at that edge.
- Reset asserted mid-stream blanks the display at the next edge. It does not act asynchronously.
- Back-to-back different inputs on consecutive edges produce the corresponding patterns on consecutive cycles, with no holes or repeats.
- Holding the input constant holds the output constant.
- Before the first reset the register content is unspecified. Integration must reset before use.

## Test plan
- Reset: reset=1 for 2 edges with binary_number=0x8 -> all segments 0. Release reset -> 1111111 one edge later.
- Directed sequence, one value per clock, sampled ¼ period after each edge:
  - 0x0 -> 1111110
  - 0x5 -> 1011011
  - 0xC -> 1001110
  - 0xB -> 0011111
  - 0xF -> 1000111
- Exhaustive: sweep 0x0–0xF on consecutive edges. Each output equals the table entry for the input sampled one edge earlier.
- Latency and stability:
  - Change binary_number 0x1→0x7 mid-cycle: output stays 0110000 until the next rising edge, then becomes 1110000.
  - Glitch the input and return it before the edge: no output change.
- Mid-stream reset: while displaying 0x9 (1111011), assert reset for one edge -> 0000000. Deassert -> the decode of the current input returns on the following edge.
- ACTIVE_LOW=1 instance:
  - 0x0 -> 0000001.
  - 0xE -> 0110000.
  - Reset -> 1111111.
